// File: rtl/mem_buffer_pkg.sv
// Shared types and default geometry for the cache-to-memory write-back path.
package mem_buffer_pkg;
  localparam int NUM_MEM_BYTES_DEF   = 256;
  localparam int CACHE_LINE_SIZE_DEF = 16;
  localparam int DEPTH_DEF           = 4;
  localparam int MEM_ADDR_WIDTH_DEF  = $clog2(NUM_MEM_BYTES_DEF / CACHE_LINE_SIZE_DEF);

  typedef logic [CACHE_LINE_SIZE_DEF*8-1:0] line_t;
  typedef logic [MEM_ADDR_WIDTH_DEF-1:0]    line_addr_t;

  typedef struct packed {
    logic       valid;
    line_addr_t addr;
    line_t      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_match_unit.sv
// Parallel lookup of one line address against every buffer entry.
// Feeds both the write-coalesce and the read-forwarding paths.
module wb_match_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int LW    = 128
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] addr_i,
  input  logic [DEPTH-1:0][LW-1:0] data_i,
  input  logic [AW-1:0]            key_i,
  output logic [DEPTH-1:0]         hit_o,
  output logic                     hit_any_o,
  output logic [LW-1:0]            hit_data_o
);
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign hit_o[g] = valid_i[g] && (addr_i[g] == key_i);
  end

  assign hit_any_o = |hit_o;

  // At most one entry per address is valid, so OR-ing the hits is a clean mux.
  always_comb begin
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (hit_o[i]) hit_data_o = hit_data_o | data_i[i];
  end
endmodule

// File: rtl/line_write_buffer.sv
// Posted write-back FIFO between the data cache and line-wide memory:
// coalesces repeat write-backs, drains on idle cycles, forwards to fills.
module line_write_buffer
  import mem_buffer_pkg::*;
#(
  parameter int NUM_MEM_BYTES   = NUM_MEM_BYTES_DEF,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
  parameter int MEM_ADDR_WIDTH  = $clog2(NUM_MEM_BYTES / CACHE_LINE_SIZE),
  parameter int DEPTH           = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cache_write,
  input  logic                         cache_read,
  input  logic [MEM_ADDR_WIDTH-1:0]    cache_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] cache_wdata,
  output logic [CACHE_LINE_SIZE*8-1:0] cache_rdata,
  output logic                         buf_full,
  output logic                         buf_empty,
  output logic                         mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  output logic [CACHE_LINE_SIZE*8-1:0] mem_wdata,
  input  logic [CACHE_LINE_SIZE*8-1:0] mem_rdata
);
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int LW = CACHE_LINE_SIZE * 8;
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][LW-1:0] data_q;
  logic [PW-1:0]            head_q, tail_q;
  logic [PW:0]              count_q, count_d;

  logic [DEPTH-1:0] hit;
  logic             hit_any;
  logic [LW-1:0]    hit_data;
  logic [AW-1:0]    head_addr;
  logic             drain, wr_hit, wr_alloc;

  wb_match_unit #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) u_match (
    .valid_i    (valid_q),
    .addr_i     (addr_q),
    .data_i     (data_q),
    .key_i      (cache_addr),
    .hit_o      (hit),
    .hit_any_o  (hit_any),
    .hit_data_o (hit_data)
  );

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == (PW+1)'(DEPTH));
  assign head_addr = addr_q[head_q];

  // A write landing on the head line holds the drain off so stale data never commits.
  assign drain    = rstn && !buf_empty && !cache_read &&
                    !(cache_write && (cache_addr == head_addr));
  assign wr_hit   = cache_write && hit_any;
  assign wr_alloc = cache_write && !hit_any && !buf_full;
  assign count_d  = count_q + (PW+1)'(wr_alloc) - (PW+1)'(drain);

  assign mem_wr_en   = drain;
  assign mem_addr    = drain ? head_addr : cache_addr;
  assign mem_wdata   = data_q[head_q];
  assign cache_rdata = (!cache_write && hit_any) ? hit_data : mem_rdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
        if (wr_hit && hit[i]) data_q[i] <= cache_wdata;
      if (wr_alloc) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= cache_addr;
        data_q[tail_q]  <= cache_wdata;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn)
      assert (!(cache_write && !hit_any && buf_full))
        else $warning("line_write_buffer: new-line write-back while full was dropped");
  end
endmodule

// File: tb/tb_line_write_buffer.sv
// Directed bench for line_write_buffer with a line-wide memory model.
module tb_line_write_buffer;
  import mem_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rstn, cache_write, cache_read;
  line_addr_t cache_addr, mem_addr;
  line_t      cache_wdata, cache_rdata, mem_wdata, mem_rdata;
  logic       buf_full, buf_empty, mem_wr_en;

  line_t mem [16];
  int    nwr = 0;
  logic  aa_seen = 1'b0;
  int    errors = 0, checks = 0;
  int    snap;

  localparam line_t LA5 = {16{8'hA5}};
  localparam line_t L10 = {16{8'h10}};
  localparam line_t L20 = {16{8'h20}};
  localparam line_t L30 = {16{8'h30}};
  localparam line_t L40 = {16{8'h40}};
  localparam line_t L77 = {16{8'h77}};
  localparam line_t L11 = {16{8'h11}};
  localparam line_t LAA = {16{8'hAA}};
  localparam line_t LBB = {16{8'hBB}};
  localparam line_t LCC = {16{8'hCC}};

  always #5 clk = ~clk;

  line_write_buffer dut (
    .clk(clk), .rstn(rstn), .cache_write(cache_write), .cache_read(cache_read),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .buf_full(buf_full), .buf_empty(buf_empty), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      nwr <= nwr + 1;
      if (mem_wdata == LAA) aa_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at posedge+1, sample at posedge+5 (negedge).
  task automatic drive(input logic w, input logic r, input line_addr_t a, input line_t d);
    cache_write = w; cache_read = r; cache_addr = a; cache_wdata = d;
    #4;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 4'd0, '0);
    tick(); tick();
    chk("rst_empty", buf_empty, 1'b1);
    chk("rst_full",  buf_full,  1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    rstn = 1'b1;

    // Single write-back: enqueue edge, then drain edge.
    drive(1'b1, 1'b0, 4'd3, LA5);
    chk("single_no_early_wr", mem_wr_en, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("single_wr_en",  mem_wr_en, 1'b1);
    chk("single_addr",   mem_addr, 4'd3);
    chk("single_wdata",  mem_wdata, LA5);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("single_empty",  buf_empty, 1'b1);
    chk("single_mem3",   mem[3], LA5);

    // Fill while the cache is reading, then coalesce into a full buffer.
    drive(1'b1, 1'b1, 4'd0, L10); tick();
    drive(1'b1, 1'b1, 4'd1, L20); tick();
    drive(1'b1, 1'b1, 4'd2, L30); tick();
    drive(1'b1, 1'b1, 4'd3, L40);
    chk("fill_not_full_3", buf_full, 1'b0);
    chk("fill_blocked",    mem_wr_en, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd2, L77);
    chk("fill_full",       buf_full, 1'b1);
    tick();
    drive(1'b0, 1'b1, 4'd2, '0);
    chk("coal_still_full", buf_full, 1'b1);
    chk("coal_fwd2",       cache_rdata, L77);
    chk("coal_no_wr",      mem_wr_en, 1'b0);
    tick();

    // Full violation: new address dropped, state kept.
    drive(1'b1, 1'b1, 4'd9, LCC);
    tick();
    drive(1'b0, 1'b1, 4'd9, '0);
    chk("viol_full",  buf_full, 1'b1);
    chk("viol_fwd9",  cache_rdata, line_t'(0));
    tick();
    drive(1'b0, 1'b1, 4'd0, '0);
    chk("viol_fwd0",  cache_rdata, L10);
    tick();

    // Release the read: drain in FIFO order with the coalesced data.
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("drain0_en", mem_wr_en, 1'b1); chk("drain0_addr", mem_addr, 4'd0); chk("drain0_data", mem_wdata, L10);
    tick(); drive(1'b0, 1'b0, 4'd0, '0);
    chk("drain1_en", mem_wr_en, 1'b1); chk("drain1_addr", mem_addr, 4'd1); chk("drain1_data", mem_wdata, L20);
    tick(); drive(1'b0, 1'b0, 4'd0, '0);
    chk("drain2_en", mem_wr_en, 1'b1); chk("drain2_addr", mem_addr, 4'd2); chk("drain2_data", mem_wdata, L77);
    tick(); drive(1'b0, 1'b0, 4'd0, '0);
    chk("drain3_en", mem_wr_en, 1'b1); chk("drain3_addr", mem_addr, 4'd3); chk("drain3_data", mem_wdata, L40);
    tick(); drive(1'b0, 1'b0, 4'd0, '0);
    chk("drain_empty", buf_empty, 1'b1);
    chk("drain_nowr",  mem_wr_en, 1'b0);
    chk("drain_mem2",  mem[2], L77);
    chk("drain_mem9",  mem[9], line_t'(0));

    // Forwarding from the buffer versus memory.
    drive(1'b1, 1'b0, 4'd5, L11); tick();
    drive(1'b0, 1'b1, 4'd5, '0);
    chk("fwd5_data", cache_rdata, L11);
    chk("fwd5_nowr", mem_wr_en, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'd6, '0);
    chk("fwd6_data", cache_rdata, mem[6]);
    chk("fwd6_nowr", mem_wr_en, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("fwd_drain5", mem_addr, 4'd5);
    tick();

    // Head-coalesce suppresses the drain of the stale line.
    drive(1'b1, 1'b0, 4'd1, LAA); tick();
    drive(1'b1, 1'b0, 4'd1, LBB);
    chk("hc_suppress", mem_wr_en, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("hc_wr_en", mem_wr_en, 1'b1);
    chk("hc_data",  mem_wdata, LBB);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("hc_mem1",  mem[1], LBB);
    chk("hc_no_aa", aa_seen, 1'b0);
    chk("hc_empty", buf_empty, 1'b1);

    // Reset with pending entries discards them.
    drive(1'b1, 1'b1, 4'd7, LCC); tick();
    drive(1'b1, 1'b1, 4'd8, LCC); tick();
    rstn = 1'b0;
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("rst2_no_wr", mem_wr_en, 1'b0);
    tick(); tick();
    rstn = 1'b1;
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("rst2_empty", buf_empty, 1'b1);
    chk("rst2_full",  buf_full, 1'b0);
    chk("rst2_wr_en", mem_wr_en, 1'b0);
    snap = nwr;
    tick(); tick(); tick();
    drive(1'b0, 1'b0, 4'd0, '0);
    chk("rst2_nwr",  32'(nwr), 32'(snap));
    chk("rst2_mem7", mem[7], line_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
